id_ex_stage: RTL

- ID/EX pipeline stage downstream of the register file: captures the two 16-bit read-port values driven on the file's bitlines, plus decoded fields and control, at each clock.
- Applies write-through bypass from WB, since the file writes and reads in the same cycle.
- Forces R0 reads to zero.
- Detects load-use hazards and inserts bubbles. Honours external stall and flush.

---
 rtl/id_ex_stage_pkg.sv | 29 ++
 rtl/id_ex_stage_if.sv | 45 ++++
 rtl/id_ex_operand_sel.sv | 14 +
 rtl/id_ex_stage.sv | 64 ++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths, opcode encodings and the EX register layout
// for the ID/EX pipeline stage.
package id_ex_stage_pkg;
    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int OPC_W  = 4;
    localparam logic [REG_AW-1:0] R0 = '0;
    localparam logic [OPC_W-1:0] OPC_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OPC_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OPC_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OPC_AND = 4'h3;
    localparam logic [OPC_W-1:0] OPC_OR  = 4'h4;
    localparam logic [OPC_W-1:0] OPC_LW  = 4'h5;
    localparam logic [OPC_W-1:0] OPC_SW  = 4'h6;
    localparam logic [OPC_W-1:0] OPC_BEQ = 4'h7;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
        logic [OPC_W-1:0]  opcode;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } ex_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, WB write port and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if import id_ex_stage_pkg::*; ();
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_rf_data1;
    logic [DATA_W-1:0] id_rf_data2;
    logic [DATA_W-1:0] id_imm;
    logic [OPC_W-1:0]  id_opcode;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              wb_write_en;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_data1;
    logic [DATA_W-1:0] ex_data2;
    logic [DATA_W-1:0] ex_imm;
    logic [OPC_W-1:0]  ex_opcode;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              load_use_hazard;
    modport master (
        output stall, flush, id_valid, id_rs, id_rt, id_rd, id_rf_data1, id_rf_data2,
               id_imm, id_opcode, id_reg_write, id_mem_read, id_mem_write,
               wb_write_en, wb_rd, wb_data,
        input  ex_valid, ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_opcode,
               ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard
    );
    modport slave (
        input  stall, flush, id_valid, id_rs, id_rt, id_rd, id_rf_data1, id_rf_data2,
               id_imm, id_opcode, id_reg_write, id_mem_read, id_mem_write,
               wb_write_en, wb_rd, wb_data,
        output ex_valid, ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_opcode,
               ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard
    );
endinterface

// File: rtl/id_ex_operand_sel.sv
// id_ex_operand_sel: picks one source operand from R0, the WB write-through bypass
// or the register-file bitline value.
module id_ex_operand_sel import id_ex_stage_pkg::*; (
    input  logic [REG_AW-1:0] reg_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              wb_write_en_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] data_o
);
    // reg_i != R0 on the bypass arm already implies wb_rd_i != R0
    assign data_o = (reg_i == R0) ? '0 :
                    (wb_write_en_i && wb_rd_i == reg_i) ? wb_data_i : rf_data_i;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB bypass, R0 forcing, load-use bubbles,
// stall and flush. Optional bubble counter when ID_EX_BUBBLE_STATS_EN is defined.
module id_ex_stage import id_ex_stage_pkg::*; (
    input  logic clk,
    input  logic rst,
    id_ex_stage_if.slave bus
`ifdef ID_EX_BUBBLE_STATS_EN
    ,
    output logic [15:0] bubble_count
`endif
);
    logic [DATA_W-1:0] op1, op2;
    logic hazard;
    ex_t ex_q, ex_d, id_ex;

    id_ex_operand_sel u_sel_rs (
        .reg_i(bus.id_rs), .rf_data_i(bus.id_rf_data1), .wb_write_en_i(bus.wb_write_en),
        .wb_rd_i(bus.wb_rd), .wb_data_i(bus.wb_data), .data_o(op1)
    );
    id_ex_operand_sel u_sel_rt (
        .reg_i(bus.id_rt), .rf_data_i(bus.id_rf_data2), .wb_write_en_i(bus.wb_write_en),
        .wb_rd_i(bus.wb_rd), .wb_data_i(bus.wb_data), .data_o(op2)
    );

    assign hazard = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != R0) &
                    ((ex_q.rd == bus.id_rs) | (ex_q.rd == bus.id_rt));

    // flush beats stall; stall beats hazard; an invalid ID slot loads as a bubble
    always_comb begin
        id_ex = '{valid: 1'b1, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                  data1: op1, data2: op2, imm: bus.id_imm, opcode: bus.id_opcode,
                  reg_write: bus.id_reg_write, mem_read: bus.id_mem_read,
                  mem_write: bus.id_mem_write};
        ex_d = (bus.flush | (!bus.stall & (hazard | !bus.id_valid))) ? '0 :
               bus.stall ? ex_q : id_ex;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ex_q <= '0;
        else      ex_q <= ex_d;
    end

    assign bus.ex_valid        = ex_q.valid;
    assign bus.ex_rs           = ex_q.rs;
    assign bus.ex_rt           = ex_q.rt;
    assign bus.ex_rd           = ex_q.rd;
    assign bus.ex_data1        = ex_q.data1;
    assign bus.ex_data2        = ex_q.data2;
    assign bus.ex_imm          = ex_q.imm;
    assign bus.ex_opcode       = ex_q.opcode;
    assign bus.ex_reg_write    = ex_q.reg_write;
    assign bus.ex_mem_read     = ex_q.mem_read;
    assign bus.ex_mem_write    = ex_q.mem_write;
    assign bus.load_use_hazard = hazard;

`ifdef ID_EX_BUBBLE_STATS_EN
    logic [15:0] bubble_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bubble_q <= '0;
        else if ((bus.flush | (!bus.stall & hazard)) && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
    end
    assign bubble_count = bubble_q;
`endif
endmodule
